fp_operand_stage: RTL and testbench

FP_OPERAND_STAGE -- requirements
Module: fp_operand_stage

---
 rtl/fp_operand_stage.sv | 136 +++++++++++++
 tb/tb_fp_operand_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_stage.sv
// Operand decode stage for an FP32 multiplier: decodes each operand pair on entry and
// holds up to two decoded entries in a small FIFO in front of the multiplier.
module fp_operand_stage #(
  parameter bit FTZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_sign,
  output logic [9:0]  out_exp_sum,
  output logic [23:0] out_man_a,
  output logic [23:0] out_man_b,
  output logic        out_zero,
  output logic        out_inf,
  output logic        out_nan,
  output logic [15:0] accepted_cnt
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [9:0]  exp_sum;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        zero;
    logic        inf;
    logic        nan;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      dec;
  entry_t      head;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] acc_q, acc_d;
  logic        push, pop;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [9:0]  eva, evb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Operand decode at push time; "zero" includes flushed subnormals when FTZ is set.
  always_comb begin
    ea     = in_a[30:23];
    eb     = in_b[30:23];
    fa     = in_a[22:0];
    fb     = in_b[22:0];
    a_zero = (ea == 8'd0) && (FTZ || (fa == 23'd0));
    b_zero = (eb == 8'd0) && (FTZ || (fb == 23'd0));
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    eva    = ((ea == 8'd0) && !FTZ) ? 10'd1 : {2'b00, ea};
    evb    = ((eb == 8'd0) && !FTZ) ? 10'd1 : {2'b00, eb};

    dec.a       = in_a;
    dec.b       = in_b;
    dec.sign    = in_a[31] ^ in_b[31];
    dec.exp_sum = eva + evb - 10'd127;
    dec.man_a   = ((ea == 8'd0) && FTZ) ? 24'd0 : {ea != 8'd0, fa};
    dec.man_b   = ((eb == 8'd0) && FTZ) ? 24'd0 : {eb != 8'd0, fb};
    dec.nan     = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    dec.inf     = !dec.nan && (a_inf || b_inf);
    dec.zero    = !dec.nan && !dec.inf && (a_zero || b_zero);
  end

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    acc_d      = acc_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = ~wr_ptr_q;
      acc_d           = acc_q + 16'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Registered so in_ready never depends combinationally on out_ready.
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      acc_q      <= 16'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      acc_q      <= acc_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_a        = head.a;
  assign out_b        = head.b;
  assign out_sign     = head.sign;
  assign out_exp_sum  = head.exp_sum;
  assign out_man_a    = head.man_a;
  assign out_man_b    = head.man_b;
  assign out_zero     = head.zero;
  assign out_inf      = head.inf;
  assign out_nan      = head.nan;
  assign accepted_cnt = acc_q;

endmodule

// File: tb/tb_fp_operand_stage.sv
// Self-checking bench for fp_operand_stage (FTZ=1): directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_fp_operand_stage;

  localparam bit FTZ = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_sign;
  logic [9:0]  out_exp_sum;
  logic [23:0] out_man_a, out_man_b;
  logic        out_zero, out_inf, out_nan;
  logic [15:0] accepted_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fp_operand_stage #(.FTZ(FTZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_sign     (out_sign),
    .out_exp_sum  (out_exp_sum),
    .out_man_a    (out_man_a),
    .out_man_b    (out_man_b),
    .out_zero     (out_zero),
    .out_inf      (out_inf),
    .out_nan      (out_nan),
    .accepted_cnt (accepted_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: classify each operand, then apply IEEE product rules.
  typedef struct {
    logic        sign;
    int          exp_sum;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        zero;
    logic        inf;
    logic        nan;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 nan
  function automatic int cls(input logic [31:0] x);
    int e = int'(x[30:23]);
    if (e == 255) return (x[22:0] != 0) ? 4 : 3;
    if (e == 0) return (x[22:0] == 0) ? 0 : 1;
    return 2;
  endfunction

  function automatic logic [23:0] ref_man(input logic [31:0] x);
    int c = cls(x);
    if (c == 0) return 24'd0;
    if (c == 1) return FTZ ? 24'd0 : {1'b0, x[22:0]};
    return 24'h800000 + {1'b0, x[22:0]};
  endfunction

  function automatic int ref_exp(input logic [31:0] x);
    if (x[30:23] == 8'd0 && !FTZ) return 1;
    return int'(x[30:23]);
  endfunction

  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ca = cls(a);
    int cb = cls(b);
    bit za = (ca == 0) || (ca == 1 && FTZ);
    bit zb = (cb == 0) || (cb == 1 && FTZ);
    r.sign    = a[31] ^ b[31];
    r.exp_sum = ref_exp(a) + ref_exp(b) - 127;
    r.man_a   = ref_man(a);
    r.man_b   = ref_man(b);
    r.nan     = (ca == 4) || (cb == 4) || (ca == 3 && zb) || (cb == 3 && za);
    r.inf     = !r.nan && (ca == 3 || cb == 3);
    r.zero    = !r.nan && !r.inf && (za || zb);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s = 1'($urandom_range(0, 1));
    int          k = $urandom_range(0, 7);
    logic [22:0] f = 23'($urandom);
    logic [7:0]  e = 8'($urandom_range(1, 254));
    case (k)
      0:       return {s, 8'd0, 23'd0};
      1:       return {s, 8'd0, 23'($urandom_range(1, 23'h7FFFFF))};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      default: return {s, e, f};
    endcase
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (accepted_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", accepted_cnt); end
    n_cmp++; if ({out_a, out_b, out_man_a, out_exp_sum} !== '0) begin n_err++; $display("FAIL rst_data: got %h %h %h %h want 0", out_a, out_b, out_man_a, out_exp_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_early: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_examples();
    logic [31:0] ta [2] = '{32'h40F00000, 32'h40200000};
    logic [31:0] tb [2] = '{32'h40F00000, 32'h3FC00000};
    logic [9:0]  te [2] = '{10'd131, 10'd128};
    logic [23:0] tma [2] = '{24'hF00000, 24'hA00000};
    logic [23:0] tmb [2] = '{24'hF00000, 24'hC00000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tb[i]; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ex%0d_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (out_sign !== 1'b0) begin n_err++; $display("FAIL ex%0d_sign: got %b want 0", i, out_sign); end
      n_cmp++; if (out_exp_sum !== te[i]) begin n_err++; $display("FAIL ex%0d_exp: got %0d want %0d", i, out_exp_sum, te[i]); end
      n_cmp++; if (out_man_a !== tma[i] || out_man_b !== tmb[i]) begin n_err++; $display("FAIL ex%0d_man: got %h %h want %h %h", i, out_man_a, out_man_b, tma[i], tmb[i]); end
      n_cmp++; if ({out_nan, out_inf, out_zero} !== 3'b000) begin n_err++; $display("FAIL ex%0d_flags: got %b want 000", i, {out_nan, out_inf, out_zero}); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ex%0d_drain: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta [3] = '{32'h7F800000, 32'hFF800000, 32'h00000001};
    logic [31:0] tb [3] = '{32'h00000000, 32'h40000000, 32'h40000000};
    logic [2:0]  tf [3] = '{3'b100, 3'b010, 3'b001};  // {nan, inf, zero}
    logic        ts [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tb[i];
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if ({out_nan, out_inf, out_zero} !== tf[i]) begin n_err++; $display("FAIL sp%0d_flags: got %b want %b", i, {out_nan, out_inf, out_zero}, tf[i]); end
      n_cmp++; if (out_sign !== ts[i]) begin n_err++; $display("FAIL sp%0d_sign: got %b want %b", i, out_sign, ts[i]); end
      if (i == 2) begin
        n_cmp++; if (out_man_a !== 24'd0) begin n_err++; $display("FAIL sp_ftz_man: got %h want 0", out_man_a); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40400000;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    in_a = 32'h40800000; in_b = 32'h40A00000;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
    in_a = 32'h40C00000; in_b = 32'h40E00000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (accepted_cnt !== 16'd2) begin n_err++; $display("FAIL bp_cnt: got %0d want 2", accepted_cnt); end
      n_cmp++; if (out_a !== 32'h3F800000 || out_b !== 32'h40400000) begin n_err++; $display("FAIL bp_head: got %h %h want 3f800000 40400000", out_a, out_b); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    n_cmp++; if (out_a !== 32'h40800000) begin n_err++; $display("FAIL bp_head2: got %h want 40800000", out_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [10];
    logic [31:0] pb [10];
    for (int i = 0; i < 10; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_hs%0d: got %b%b want 11", k, out_valid, in_ready); end
        n_cmp++; if (out_a !== pa[k-1] || out_b !== pb[k-1]) begin n_err++; $display("FAIL b2b_order%0d: got %h %h want %h %h", k, out_a, out_b, pa[k-1], pb[k-1]); end
        n_cmp++; if (accepted_cnt !== 16'(k)) begin n_err++; $display("FAIL b2b_cnt%0d: got %0d want %0d", k, accepted_cnt, k); end
      end
      in_valid = 1'b1; in_a = pa[k]; in_b = pb[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (out_a !== pa[9]) begin n_err++; $display("FAIL b2b_last: got %h want %h", out_a, pa[9]); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    pair_t q[$];
    pair_t p;
    exp_t  e;
    int    acc = 0;
    bit    push, pop;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, q.size() > 0); end
      n_cmp++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, q.size() < 2); end
      n_cmp++; if (accepted_cnt !== 16'(acc)) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, accepted_cnt, acc); end
      if (q.size() > 0) begin
        e = ref_model(q[0].a, q[0].b);
        n_cmp++;
        if (out_a !== q[0].a || out_b !== q[0].b || out_sign !== e.sign
            || int'($signed(out_exp_sum)) != e.exp_sum || out_man_a !== e.man_a
            || out_man_b !== e.man_b || {out_nan, out_inf, out_zero} !== {e.nan, e.inf, e.zero}) begin
          n_err++;
          $display("FAIL rnd_head c%0d: got a=%h b=%h s=%b e=%0d ma=%h mb=%h f=%b want a=%h b=%h s=%b e=%0d ma=%h mb=%h f=%b",
                   cyc, out_a, out_b, out_sign, $signed(out_exp_sum), out_man_a, out_man_b,
                   {out_nan, out_inf, out_zero}, q[0].a, q[0].b, e.sign, e.exp_sum, e.man_a,
                   e.man_b, {e.nan, e.inf, e.zero});
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      p.a = rand_op(); p.b = rand_op();
      in_a = p.a; in_b = p.b;
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      @(negedge clk);
      if (pop) void'(q.pop_front());
      if (push) begin q.push_back(p); acc++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_valid = 1'b1; in_a = 32'h40F00000; in_b = 32'h40F00000;
    @(negedge clk);
    in_a = 32'h40200000; in_b = 32'h3FC00000;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mr_full: got %b%b want 10", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b want 0", out_valid); end
    n_cmp++; if (accepted_cnt !== 16'd0) begin n_err++; $display("FAIL mr_cnt: got %0d want 0", accepted_cnt); end
    n_cmp++; if (in_ready !== 1'b0 || out_a !== 32'd0) begin n_err++; $display("FAIL mr_data: got %b %h want 0 0", in_ready, out_a); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mr_after: got %b%b want 01", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_examples();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
